// File: rtl/prog_loader.sv
// Boot-time program loader: parses a framed byte stream, writes big-endian 32-bit
// words into instruction memory from address 0, and releases the core on a good checksum.
module prog_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_RUN, S_ERR
  } state_e;

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [7:0]            xor_q, xor_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  run_q, run_d;
  logic                  err_q, err_d;

  logic        accept;
  logic [15:0] hdr_count;
  logic [31:0] full_word;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {cnt_hi_q, in_data};
  // Only the top three bytes are kept; the fourth arrives with the write itself.
  assign full_word = {word_q, in_data};
  assign last_word = (32'(idx_q) + 32'd1) == 32'(count_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HDR_HI;
      cnt_hi_q   <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      idx_q      <= '0;
      xor_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_hi_d   = cnt_hi_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (accept) begin
      unique case (state_q)
        S_HDR_HI: begin
          cnt_hi_d = in_data;
          xor_d    = xor_q ^ in_data;
          state_d  = S_HDR_LO;
        end
        S_HDR_LO: begin
          count_d = hdr_count;
          xor_d   = xor_q ^ in_data;
          if (32'(hdr_count) > DEPTH)  state_d = S_ERR;
          else if (hdr_count == 16'd0) state_d = S_CSUM;
          else                         state_d = S_DATA;
        end
        S_DATA: begin
          xor_d      = xor_q ^ in_data;
          word_d     = full_word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = idx_q[ADDR_WIDTH-1:0];
            wdata_d = full_word;
            idx_d   = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (last_word) state_d = S_CSUM;
          end
        end
        S_CSUM:  state_d = (in_data == xor_q) ? S_RUN : S_ERR;
        default: ;
      endcase
    end
  end

  // Status flags are registered so the core's reset input never sees a decode glitch.
  always_comb begin
    run_d     = (state_d == S_RUN);
    err_d     = (state_d == S_ERR);
    in_ready  = (state_q != S_RUN) && (state_q != S_ERR);
    cpu_run   = run_q;
    load_done = run_q;
    load_err  = err_q;
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 16-word memory; each scenario task checks inline.
module tb_prog_loader;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          load_done;
  logic          load_err;

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int dbl_we = 0;
  logic prev_we = 1'b0;
  logic [AW+31:0] wr_q[$];
  logic [7:0] frame[$];

  // Write log, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    if (imem_we && prev_we) dbl_we++;
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < frame.size(); i++) begin
      if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(frame[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset;
    in_valid = 1'b0;
    in_data  = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    wr_q.delete();
  endtask

  // XOR of 00 02 DE AD BE EF 12 34 56 78 is 0x28.
  task automatic load_nominal(input logic [7:0] csum);
    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    frame.push_back(csum);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    n_vec++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_err} !==
        {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_nominal;
    do_reset();
    load_nominal(8'h28);
    for (int i = 0; i < 6; i++) send_byte(frame[i]);
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 4'd0, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL nominal_w0 got we=%b addr=%h data=%h want 1/0/deadbeef", imem_we, imem_addr, imem_wdata);
    end
    send_byte(frame[6]);
    n_vec++;
    if (imem_we !== 1'b0) begin n_err++; $display("FAIL nominal_we_pulse got %b want 0", imem_we); end
    for (int i = 7; i < 10; i++) send_byte(frame[i]);
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, cpu_run} !== {1'b1, 4'd1, 32'h12345678, 1'b0}) begin
      n_err++;
      $display("FAIL nominal_w1 got we=%b addr=%h data=%h run=%b want 1/1/12345678/0",
               imem_we, imem_addr, imem_wdata, cpu_run);
    end
    send_byte(frame[10]);
    in_valid = 1'b0;
    n_vec++;
    if ({cpu_run, load_done, in_ready, load_err} !== 4'b1100) begin
      n_err++;
      $display("FAIL nominal_run got run=%b done=%b rdy=%b err=%b want 1/1/0/0", cpu_run, load_done, in_ready, load_err);
    end
    idle(3);
    n_vec++;
    if ({cpu_run, load_done, in_ready, wr_q.size()} !== {3'b110, 32'd2}) begin
      n_err++;
      $display("FAIL nominal_sticky got run=%b done=%b rdy=%b writes=%0d want 1/1/0/2",
               cpu_run, load_done, in_ready, wr_q.size());
    end
  endtask

  task automatic test_async_reset_run;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({cpu_run, load_done, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL async_run_drop got run=%b done=%b rdy=%b want 0/0/1", cpu_run, load_done, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_bad_csum;
    do_reset();
    load_nominal(8'h3D);
    send_frame(0);
    n_vec++;
    if ({load_err, cpu_run, load_done, in_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL badcsum_err got err=%b run=%b done=%b rdy=%b want 1/0/0/0", load_err, cpu_run, load_done, in_ready);
    end
    idle(1);
    n_vec++;
    if (wr_q.size() !== 2 || wr_q[0] !== {4'd0, 32'hDEADBEEF} || wr_q[1] !== {4'd1, 32'h12345678}) begin
      n_err++;
      $display("FAIL badcsum_writes got n=%0d want 2 words at 0,1", wr_q.size());
    end
    for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
    idle(2);
    n_vec++;
    if ({load_err, cpu_run, in_ready, wr_q.size()} !== {3'b100, 32'd2}) begin
      n_err++;
      $display("FAIL badcsum_locked got err=%b run=%b rdy=%b writes=%0d want 1/0/0/2",
               load_err, cpu_run, in_ready, wr_q.size());
    end
  endtask

  task automatic test_oversize;
    do_reset();
    send_byte(8'h00);
    n_vec++;
    if ({load_err, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL oversize_early got err=%b rdy=%b want 0/1", load_err, in_ready);
    end
    send_byte(8'h11);
    n_vec++;
    if ({load_err, in_ready, cpu_run} !== 3'b100) begin
      n_err++;
      $display("FAIL oversize_err got err=%b rdy=%b run=%b want 1/0/0", load_err, in_ready, cpu_run);
    end
    for (int i = 0; i < 8; i++) send_byte(8'h55);
    idle(2);
    n_vec++;
    if (wr_q.size() !== 0) begin
      n_err++;
      $display("FAIL oversize_nowrite got %0d writes want 0", wr_q.size());
    end
  endtask

  task automatic test_zero;
    do_reset();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    n_vec++;
    if ({cpu_run, load_done, load_err} !== 3'b110) begin
      n_err++;
      $display("FAIL zero_run got run=%b done=%b err=%b want 1/1/0", cpu_run, load_done, load_err);
    end
    idle(2);
    n_vec++;
    if (wr_q.size() !== 0) begin n_err++; $display("FAIL zero_nowrite got %0d writes want 0", wr_q.size()); end
  endtask

  task automatic test_full_depth;
    logic [7:0]  x;
    logic [31:0] w;
    do_reset();
    frame = '{8'h00, 8'h10};
    x = 8'h10;
    for (int i = 0; i < 16; i++) begin
      w = 32'h5A3C9617 ^ {4{8'(i)}};
      for (int b = 3; b >= 0; b--) begin
        frame.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    frame.push_back(x);
    send_frame(0);
    n_vec++;
    if ({cpu_run, load_done, load_err} !== 3'b110) begin
      n_err++;
      $display("FAIL full_run got run=%b done=%b err=%b want 1/1/0", cpu_run, load_done, load_err);
    end
    idle(1);
    n_vec++;
    if (wr_q.size() !== 16) begin
      n_err++;
      $display("FAIL full_count got %0d writes want 16", wr_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_vec++;
        if (wr_q[i] !== {4'(i), 32'h5A3C9617 ^ {4{8'(i)}}}) begin
          n_err++;
          $display("FAIL full_word%0d got %h want %h", i, wr_q[i], {4'(i), 32'h5A3C9617 ^ {4{8'(i)}}});
        end
      end
    end
  endtask

  task automatic test_stall;
    do_reset();
    load_nominal(8'h28);
    send_frame(3);
    idle(2);
    n_vec++;
    if (wr_q.size() !== 2 || wr_q[0] !== {4'd0, 32'hDEADBEEF} || wr_q[1] !== {4'd1, 32'h12345678} ||
        cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL stall_writes got n=%0d run=%b want 2 words at 0,1 and run=1", wr_q.size(), cpu_run);
    end
  endtask

  task automatic test_midload_reset;
    do_reset();
    load_nominal(8'h28);
    for (int i = 0; i < 6; i++) send_byte(frame[i]);
    in_valid = 1'b0;
    n_vec++;
    if (imem_we !== 1'b1) begin n_err++; $display("FAIL midload_pre got we=%b want 1", imem_we); end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_err} !==
        {1'b1, 1'b0, {AW{1'b0}}, 32'h0, 3'b000}) begin
      n_err++;
      $display("FAIL midload_reset got rdy=%b we=%b addr=%h data=%h run=%b done=%b err=%b",
               in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    wr_q.delete();
    // XOR of 00 01 CA FE BA BE is 0x31.
    frame = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
    send_frame(0);
    idle(1);
    n_vec++;
    if (wr_q.size() !== 1 || wr_q[0] !== {4'd0, 32'hCAFEBABE} || cpu_run !== 1'b1) begin
      n_err++;
      $display("FAIL fresh_frame got n=%0d first=%h run=%b want 1 write 0:cafebabe run=1",
               wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : '0, cpu_run);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_async_reset_run();
    test_bad_csum();
    test_oversize();
    test_zero();
    test_full_depth();
    test_stall();
    test_midload_reset();
    n_vec++;
    if (dbl_we !== 0) begin n_err++; $display("FAIL we_two_cycles got %0d want 0", dbl_we); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
